// File: rtl/cos_job_issuer_pkg.sv
// cos_job_issuer_pkg
//   Shared types and default sizing for the cos job issuer.
//   - issuer_state_t : job sequencing states IDLE -> LOAD -> START -> WAIT -> RESP
//   - *_DEF          : default operand width, start pulse width and watchdog limit
package cos_job_issuer_pkg;

   localparam int DATA_W_DEF      = 16;
   localparam int START_CYC_DEF   = 2;
   localparam int TIMEOUT_CYC_DEF = 64;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } issuer_state_t;

endpackage

// File: rtl/cos_job_issuer_if.sv
// cos_job_issuer_if
//   Bundles the three handshakes around the issuer:
//   - upstream operand stream   : in_valid / in_ready / in_x
//   - controller/datapath pair  : dp_x / dp_ld / cu_start / cu_done / dp_result
//   - downstream result stream  : out_valid / out_ready / out_result / out_timeout
//   Modport master is the issuer's view; modport slave is the environment's view.
interface cos_job_issuer_if
   import cos_job_issuer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_x;
   logic [DATA_W-1:0] dp_x;
   logic              dp_ld;
   logic              cu_start;
   logic              cu_done;
   logic [DATA_W-1:0] dp_result;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic              out_timeout;

   modport master (
      input  in_valid, in_x, cu_done, dp_result, out_ready,
      output in_ready, dp_x, dp_ld, cu_start, out_valid, out_result, out_timeout
   );

   modport slave (
      output in_valid, in_x, cu_done, dp_result, out_ready,
      input  in_ready, dp_x, dp_ld, cu_start, out_valid, out_result, out_timeout
   );

endinterface

// File: rtl/cos_job_issuer.sv
// cos_job_issuer
//   Host-side initiator for the cos accelerator start/done handshake. Takes one
//   operand per job, loads it into the datapath, pulses the controller start,
//   waits for a fresh done edge (with a watchdog) and returns the captured
//   result downstream.
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   bus   : cos_job_issuer_if.master (operand stream, controller/datapath, result stream)
//   busy  : high in every state except IDLE
// All outputs are registers decoded from the next state, so they line up with
// the current state without any combinational path from inputs.
module cos_job_issuer
   import cos_job_issuer_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int START_CYC   = START_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   cos_job_issuer_if.master bus,
   output logic             busy
);

   // One counter serves both the start pulse width and the watchdog; the
   // extra bit keeps it from ever wrapping at TIMEOUT_CYC-1.
   localparam int               CNT_W      = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   issuer_state_t     state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              done_q_r;
   logic              done_seen_r, done_seen_s;
   logic              rise_s;
   logic [DATA_W-1:0] dp_x_r, dp_x_s;
   logic [DATA_W-1:0] result_r, result_s;
   logic              timeout_r, timeout_s;
   logic              in_ready_r;
   logic              dp_ld_r;
   logic              cu_start_r;
   logic              out_valid_r;
   logic              busy_r;

   // Only a low-to-high edge of done counts, so a level left high by the
   // previous job can never complete the next one.
   assign rise_s = bus.cu_done & ~done_q_r;

   // Next-state, counter and capture logic.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      done_seen_s = done_seen_r;
      dp_x_s      = dp_x_r;
      result_s    = result_r;
      timeout_s   = timeout_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid && in_ready_r) begin
               dp_x_s  = bus.in_x;
               state_s = LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            done_seen_s = 1'b0;
            cnt_s       = {CNT_W{1'b0}};
            state_s     = START;
         end
         START: begin
            if (rise_s) begin
               done_seen_s = 1'b1;
            end else begin
               done_seen_s = done_seen_r;
            end
            if (cnt_r == START_LAST) begin
               cnt_s   = {CNT_W{1'b0}};
               state_s = WAIT;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         WAIT: begin
            // A done edge takes priority over an expiring watchdog.
            if (done_seen_r || rise_s) begin
               result_s  = bus.dp_result;
               timeout_s = 1'b0;
               state_s   = RESP;
            end else if (cnt_r == WAIT_LAST) begin
               result_s  = {DATA_W{1'b0}};
               timeout_s = 1'b1;
               state_s   = RESP;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         RESP: begin
            if (bus.out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath captures and registered output decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         done_q_r    <= 1'b1;
         done_seen_r <= 1'b0;
         dp_x_r      <= {DATA_W{1'b0}};
         result_r    <= {DATA_W{1'b0}};
         timeout_r   <= 1'b0;
         in_ready_r  <= 1'b1;
         dp_ld_r     <= 1'b0;
         cu_start_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         done_q_r    <= bus.cu_done;
         done_seen_r <= done_seen_s;
         dp_x_r      <= dp_x_s;
         result_r    <= result_s;
         timeout_r   <= timeout_s;
         in_ready_r  <= (state_s == IDLE);
         dp_ld_r     <= (state_s == LOAD);
         cu_start_r  <= (state_s == START);
         out_valid_r <= (state_s == RESP);
         busy_r      <= (state_s != IDLE);
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.dp_x        = dp_x_r;
   assign bus.dp_ld       = dp_ld_r;
   assign bus.cu_start    = cu_start_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_result  = result_r;
   assign bus.out_timeout = timeout_r;
   assign busy            = busy_r;

endmodule

// File: tb/tb_cos_job_issuer.sv
// tb_cos_job_issuer
//   Self-checking bench for cos_job_issuer. A directed table of jobs with
//   hand-derived expectations is followed by randomized jobs whose outcome is
//   predicted from the job-level rules (done edge index vs. watchdog limit).
//   The bench also plays the controller: it drops/raises cu_done at chosen
//   points of each job. Inputs change on the falling edge; outputs are sampled
//   there too, away from the active rising edge.
module tb_cos_job_issuer;

   localparam int TIMEOUT   = 64;
   localparam int START_CYC = 2;
   localparam int NEVER     = 999;

   // fall_at / rise_at: -2 = first start cycle, -1 = last start cycle,
   // k >= 0 = k-th WAIT cycle, NEVER = not driven.
   typedef struct {
      logic [15:0] x;
      logic [15:0] res;
      int          fall_at;
      int          rise_at;
      int          stall;
      bit          hold;
      bit          exp_to;
      logic [15:0] exp_res;
      int          exp_wait;
   } job_t;

   logic clk;
   logic rst;
   logic busy;
   int   checks;
   int   errors;

   cos_job_issuer_if #(.DATA_W(16)) bus ();

   cos_job_issuer dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic job_t mk(input logic [15:0] x, input logic [15:0] res, input int fall_at,
                               input int rise_at, input int stall, input bit hold, input bit exp_to,
                               input logic [15:0] exp_res, input int exp_wait);
      job_t j;
      j.x = x; j.res = res; j.fall_at = fall_at; j.rise_at = rise_at; j.stall = stall;
      j.hold = hold; j.exp_to = exp_to; j.exp_res = exp_res; j.exp_wait = exp_wait;
      return j;
   endfunction

   // Job-level prediction: a done edge happening at WAIT index k (edges in the
   // start pulse count as index 0) finishes after k+1 WAIT cycles if k is
   // within the watchdog window; otherwise the job times out after TIMEOUT cycles.
   function automatic job_t predict(input job_t j);
      job_t p;
      int   idx;
      p   = j;
      idx = (j.rise_at < 0) ? 0 : j.rise_at;
      if ((j.rise_at > j.fall_at) && (idx < TIMEOUT)) begin
         p.exp_to = 1'b0; p.exp_res = j.res; p.exp_wait = idx + 1;
      end else begin
         p.exp_to = 1'b1; p.exp_res = 16'h0000; p.exp_wait = TIMEOUT;
      end
      return p;
   endfunction

   task automatic run_job(input job_t j);
      int ld, st, wt, rdy_hi, k;
      bit got, acc;
      acc = 1'b0;
      for (k = 0; k < 20 && !acc; k++) begin
         if (bus.in_ready) acc = 1'b1;
         else @(negedge clk);
      end
      check("in_ready_before_job", 32'(acc), 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_x      = j.x;
      bus.dp_result = j.res;
      @(negedge clk);
      bus.in_valid = j.hold;
      bus.in_x     = ~j.x;
      ld = 0; st = 0; wt = 0; rdy_hi = 0; got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         if (bus.out_valid) begin
            got = 1'b1;
         end else begin
            if (bus.in_ready) rdy_hi++;
            if (bus.dp_ld) begin
               ld++;
               check("dp_x_at_load", 32'(bus.dp_x), 32'(j.x));
            end else if (bus.cu_start) begin
               st++;
               if (st == 1 && j.fall_at == -2) bus.cu_done = 1'b0;
               if (st == START_CYC && j.rise_at == -1) bus.cu_done = 1'b1;
            end else begin
               if (wt == j.fall_at) bus.cu_done = 1'b0;
               if (wt == j.rise_at) bus.cu_done = 1'b1;
               wt++;
            end
            @(negedge clk);
         end
      end
      check("resp_reached", 32'(got), 32'd1);
      check("dp_ld_cycles", 32'(ld), 32'd1);
      check("cu_start_cycles", 32'(st), 32'(START_CYC));
      check("wait_cycles", 32'(wt), 32'(j.exp_wait));
      check("in_ready_low_in_job", 32'(rdy_hi), 32'd0);
      check("out_result", 32'(bus.out_result), 32'(j.exp_res));
      check("out_timeout", 32'(bus.out_timeout), 32'(j.exp_to));
      check("dp_x_held", 32'(bus.dp_x), 32'(j.x));
      bus.dp_result = ~j.res;
      for (int s = 0; s < j.stall; s++) begin
         @(negedge clk);
         check("resp_stall_state",
               32'({bus.out_valid, bus.in_ready, bus.out_timeout, bus.out_result}),
               32'({1'b1, 1'b0, j.exp_to, j.exp_res}));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("after_resp_idle", 32'({bus.out_valid, bus.in_ready, bus.dp_ld, busy}), 32'(4'b0100));
   endtask

   job_t tbl [0:8];
   job_t rj;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.in_valid = 1'b0; bus.in_x = 16'h0000; bus.cu_done = 1'b0;
      bus.dp_result = 16'h0000; bus.out_ready = 1'b0;

      tbl[0] = mk(16'h1000, 16'h0D3C, -2,    10,    0, 1'b0, 1'b0, 16'h0D3C, 11);
      tbl[1] = mk(16'h2222, 16'hBEEF, -2,    NEVER, 2, 1'b0, 1'b1, 16'h0000, 64);
      tbl[2] = mk(16'h1234, 16'h5678, -2,    3,     5, 1'b1, 1'b0, 16'h5678, 4);
      tbl[3] = mk(16'h0ABC, 16'h0DEF, 6,     20,    1, 1'b0, 1'b0, 16'h0DEF, 21);
      tbl[4] = mk(16'h7FFF, 16'h8001, -2,    -1,    0, 1'b0, 1'b0, 16'h8001, 1);
      tbl[5] = mk(16'h0001, 16'hFFFF, -2,    63,    0, 1'b0, 1'b0, 16'hFFFF, 64);
      tbl[6] = mk(16'h3333, 16'h4444, NEVER, NEVER, 0, 1'b0, 1'b1, 16'h0000, 64);
      tbl[7] = mk(16'h5555, 16'h6666, -2,    64,    0, 1'b0, 1'b1, 16'h0000, 64);
      tbl[8] = mk(16'h0000, 16'hA5A5, -2,    0,     3, 1'b0, 1'b0, 16'hA5A5, 1);

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset_outputs",
            32'({bus.in_ready, bus.dp_ld, bus.cu_start, bus.out_valid, bus.out_timeout, busy}),
            32'(6'b100000));
      check("reset_data", 32'({bus.dp_x, bus.out_result}), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("idle_after_release", 32'({bus.in_ready, busy}), 32'(2'b10));

      // Directed table.
      for (int t = 0; t < 9; t++) run_job(tbl[t]);
      bus.in_valid = 1'b0;

      // Randomized jobs.
      for (int n = 0; n < 25; n++) begin
         rj.x     = 16'($urandom);
         rj.res   = 16'($urandom);
         rj.stall = int'($urandom_range(0, 4));
         rj.hold  = ($urandom_range(0, 3) == 0);
         rj.fall_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -2;
         k_sel: begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0 && rj.fall_at == -2) rj.rise_at = -1;
            else if (r == 1)                rj.rise_at = NEVER;
            else if (rj.fall_at < 0)        rj.rise_at = int'($urandom_range(0, 70));
            else rj.rise_at = int'($urandom_range(32'(rj.fall_at + 1), 70));
         end
         rj = predict(rj);
         run_job(rj);
      end
      bus.in_valid = 1'b0;

      // Reset during WAIT, then a clean job.
      @(negedge clk);
      bus.cu_done   = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_x      = 16'h4321;
      bus.dp_result = 16'h1111;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("in_wait_before_reset", 32'({busy, bus.cu_start, bus.out_valid}), 32'(3'b100));
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_abort",
            32'({bus.cu_start, bus.out_valid, bus.in_ready, busy, bus.dp_x}),
            32'({1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("no_result_after_abort", 32'({bus.out_valid, bus.in_ready}), 32'(2'b01));
      run_job(mk(16'h2468, 16'h1357, -2, 5, 1, 1'b0, 1'b0, 16'h1357, 6));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
